// File: rtl/commit_recovery_sequencer.sv
// commit_recovery_sequencer: arbitrates recovery requests, restores the rename map, walks the active list, then issues a refetch
module commit_recovery_sequencer #(
    parameter int COMMIT_WIDTH = 2,
    parameter int ACTIVE_LIST_ENTRY_NUM = 64,
    parameter int FLUSH_WIDTH = 2,
    localparam int CIW = $clog2(COMMIT_WIDTH),
    localparam int ACW = $clog2(ACTIVE_LIST_ENTRY_NUM) + 1,
    localparam int FW = $clog2(FLUSH_WIDTH) + 1
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           exceptionDetectedInCommitStage,
    input  logic [2:0]     refetchTypeFromCommitStage,
    input  logic [CIW-1:0] recoveryOpIndex,
    input  logic           exceptionDetectedInBackend,
    input  logic [ACW-1:0] backendFlushCount,
    input  logic [ACW-1:0] activeListValidEntryNum,
    input  logic           holdRecovery,
    output logic [1:0]     phase,
    output logic           unableToStartRecovery,
    output logic           renameLogicRecoveryRMT,
    output logic           flushValid,
    output logic [FW-1:0]  flushNum,
    output logic           refetchValid,
    output logic [2:0]     refetchType,
    output logic           recoverySource
);
    typedef enum logic [1:0] {COMMIT = 2'd0, RECOVER_0 = 2'd1, RECOVER_1 = 2'd2} phase_t;

    phase_t         state;
    logic [ACW-1:0] remaining;
    logic           flushesSelf;
    logic [ACW:0]   commitDiff;
    logic [ACW-1:0] commitCount;
    logic [FW-1:0]  flushStep;
    logic           accept;

    assign phase = state;
    assign unableToStartRecovery = (state != COMMIT) || holdRecovery;
    assign accept = !unableToStartRecovery && (exceptionDetectedInCommitStage || exceptionDetectedInBackend);
    assign flushesSelf = (refetchTypeFromCommitStage == 3'd0) || (refetchTypeFromCommitStage == 3'd4);
    assign commitDiff = {1'b0, activeListValidEntryNum} - (ACW+1)'(recoveryOpIndex) - {{ACW{1'b0}}, !flushesSelf};
    assign commitCount = commitDiff[ACW] ? '0 : commitDiff[ACW-1:0];
    assign flushStep = (remaining > ACW'(FLUSH_WIDTH)) ? FW'(FLUSH_WIDTH) : remaining[FW-1:0];

    // Phase sequencing; remaining holds what is left after the flush currently shown on flushNum
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= COMMIT;
            renameLogicRecoveryRMT <= 1'b0;
            flushValid <= 1'b0;
            flushNum <= '0;
            refetchValid <= 1'b0;
            refetchType <= 3'd0;
            recoverySource <= 1'b0;
            remaining <= '0;
        end else begin
            case (state)
                COMMIT: begin
                    refetchValid <= 1'b0;
                    if (accept) begin
                        state <= RECOVER_0;
                        renameLogicRecoveryRMT <= 1'b1;
                        remaining <= exceptionDetectedInCommitStage ? commitCount : backendFlushCount;
                        refetchType <= exceptionDetectedInCommitStage ? refetchTypeFromCommitStage : 3'd2;
                        recoverySource <= !exceptionDetectedInCommitStage;
                    end
                end
                RECOVER_0: begin
                    state <= RECOVER_1;
                    renameLogicRecoveryRMT <= 1'b0;
                    flushNum <= flushStep;
                    flushValid <= flushStep != '0;
                    remaining <= remaining - ACW'(flushStep);
                end
                RECOVER_1: begin
                    flushNum <= flushStep;
                    flushValid <= flushStep != '0;
                    remaining <= remaining - ACW'(flushStep);
                    if (remaining == '0) begin
                        state <= COMMIT;
                        refetchValid <= 1'b1;
                    end
                end
                default: state <= COMMIT;
            endcase
        end
    end
endmodule

// File: doc/commit_recovery_sequencer.md
# commit_recovery_sequencer

Sequences pipeline recovery after the commit stage or the backend detects a misprediction, refetch condition, or exception. Arbitrates between the commit-stage and backend recovery requesters and drives the pipeline phase. It restores the rename map in one cycle, then walks the active list, flushing up to FLUSH_WIDTH entries per cycle. When the walk finishes it issues a single refetch pulse to the fetch unit.

## Interface
- COMMIT_WIDTH, 2, ops examined per commit cycle; CIW = $clog2(COMMIT_WIDTH)
- ACTIVE_LIST_ENTRY_NUM, 64, active-list depth; ACW = $clog2(ACTIVE_LIST_ENTRY_NUM)+1
- FLUSH_WIDTH, 2, maximum entries flushed per cycle; FW = $clog2(FLUSH_WIDTH)+1
- clk  in  1  clock
- rst  in  1  reset; asynchronous, active-high
- exceptionDetectedInCommitStage  in  1  commit-stage recovery request
- refetchTypeFromCommitStage  in  3  commit refetch type
- recoveryOpIndex  in  CIW  lane of the recovering op, counted from the head
- exceptionDetectedInBackend  in  1  backend (branch-unit) recovery request
- backendFlushCount  in  ACW  number of entries younger than the mispredicted op
- activeListValidEntryNum  in  ACW  current active-list occupancy
- holdRecovery  in  1  external veto on starting a recovery (e.g. CSR write in flight)
- phase  out  2  0=COMMIT, 1=RECOVER_0, 2=RECOVER_1
- unableToStartRecovery  out  1  combinational; recovery cannot start this cycle
- renameLogicRecoveryRMT  out  1  restore rename map from retirement map
- flushValid  out  1  flush active-list tail entries this cycle
- flushNum  out  FW  number of entries flushed this cycle
- refetchValid  out  1  one-cycle refetch pulse
- refetchType  out  3  latched refetch type
- recoverySource  out  1  latched source; 0=commit, 1=backend

## Operation
- Refetch type encoding:
  - 0 THIS_PC
  - 1 NEXT_PC
  - 2 BRANCH_TARGET
  - 3 STORE_NEXT_PC
  - 4 THIS_PC_TO_CSR_TARGET
  - 5 NEXT_PC_TO_CSR_TARGET
  - 6 and 7 unused
- unableToStartRecovery = (phase != COMMIT) || holdRecovery.
- A request is accepted only when phase==COMMIT and !holdRecovery. Requests arriving under any other condition are dropped; requesters re-assert them.
- Commit request has priority over backend request when both arrive in the same cycle.
- Flush count for a commit request:
  - types 0 and 4 flush the recovering op itself: activeListValidEntryNum − recoveryOpIndex
  - all other types: activeListValidEntryNum − recoveryOpIndex − 1
  - result saturates at 0 and is latched into `remaining` (ACW bits)
- Flush count for a backend request: backendFlushCount, latched into `remaining`; refetchType latched as 2 (BRANCH_TARGET).
- On acceptance, also latch refetchType and recoverySource.
- State COMMIT:
  - Accept → RECOVER_0.
- State RECOVER_0 (exactly 1 cycle):
  - renameLogicRecoveryRMT=1.
  - → RECOVER_1.
- State RECOVER_1:
  - Each cycle: flushNum = min(remaining, FLUSH_WIDTH); flushValid = (flushNum != 0); remaining −= flushNum.
  - When remaining ≤ FLUSH_WIDTH at the start of the cycle, this is the last RECOVER_1 cycle → COMMIT.
  - With remaining==0 on entry, RECOVER_1 lasts one cycle with flushValid=0.
- refetchValid pulses for exactly 1 cycle: the first COMMIT cycle after RECOVER_1. refetchType and recoverySource hold their latched values until the next acceptance.
- A new request is accepted in that refetch cycle; back-to-back recoveries are legal.
- Requests that arrive while phase≠COMMIT, including a backend request arriving during commit recovery, have no effect on any state.

## Timing
- Reset (async, immediate) values:
  - phase=COMMIT
  - renameLogicRecoveryRMT=0, flushValid=0, flushNum=0
  - refetchValid=0, refetchType=0, recoverySource=0
  - remaining=0
  - unableToStartRecovery follows holdRecovery
- Reset mid-recovery returns to COMMIT with no refetch pulse.
- All outputs except unableToStartRecovery are registered.
- Request accepted at cycle t:
  - t+1: RECOVER_0
  - t+2 … t+1+max(1, ⌈N/FLUSH_WIDTH⌉): RECOVER_1
  - following cycle: COMMIT with refetchValid=1
- Total latency, request to refetch: 2 + max(1, ⌈N/FLUSH_WIDTH⌉) cycles.
- Sum of flushNum over one recovery equals the latched N exactly.

## Test plan
- Commit request with refetchType=1, recoveryOpIndex=0, activeListValidEntryNum=5 at cycle t → N=4:
  - RMT restore at t+1
  - flushNum 2,2 at t+2 and t+3
  - refetchValid=1 with refetchType=1 at t+4
- Commit request with type 0, index 1, count 2 → N=1:
  - one flush cycle with flushNum=1
  - refetch at t+3
- Backend request with backendFlushCount=0:
  - RECOVER_1 lasts one cycle with flushValid=0
  - refetch at t+3 with refetchType=2, recoverySource=1
- Commit and backend requests in the same cycle → commit wins (recoverySource=0). A backend request held high throughout the recovery is ignored until the refetch cycle, where it is accepted.
- holdRecovery=1 together with a commit request → unableToStartRecovery=1 and phase stays COMMIT. Releasing hold the next cycle with the request still asserted starts recovery.
- rst asserted during RECOVER_1 with remaining=6:
  - all outputs go to reset values immediately
  - no refetchValid pulse
  - a new request after reset is accepted normally
